// File: rtl/commit_fence_sequencer.sv
// Sequences store drain, D$/I$/TLB flushes and the pipeline flush for fence-class ops at commit.
// Outputs decode from registered state; done_o alone is also gated by req_valid_i in DONE.
module commit_fence_sequencer #(
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned CntWidth      = $clog2(TimeoutCycles)
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_valid_i,
   input  logic [1:0] req_op_i,
   input  logic       halt_i,
   input  logic       no_st_pending_i,
   output logic       dcache_flush_o,
   input  logic       dcache_flush_ack_i,
   output logic       icache_flush_o,
   output logic       tlb_flush_o,
   output logic       flush_pipeline_o,
   output logic       done_o,
   output logic       busy_o,
   output logic       timeout_o
);

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StDflush,
      StIflush,
      StTlb,
      StDone
   } state_e;

   localparam logic [1:0] OpFence  = 2'b00;
   localparam logic [1:0] OpFenceI = 2'b01;
   localparam logic [1:0] OpSfence = 2'b10;

   localparam logic [CntWidth-1:0] WdLast = CntWidth'(TimeoutCycles - 1);

   state_e              state_q, state_d;
   logic [1:0]          op_q;
   logic [CntWidth-1:0] cnt_q;
   logic                fired_q;
   logic                wd_active;
   logic                wd_enter;
   logic                wd_hit;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (req_valid_i && !halt_i) state_d = StDrain;
         end
         StDrain: begin
            if (!req_valid_i) begin
               state_d = StIdle;
            end else if (no_st_pending_i) begin
               state_d = (op_q == OpSfence) ? StTlb : StDflush;
            end
         end
         StDflush: begin
            if (dcache_flush_ack_i) state_d = (op_q == OpFenceI) ? StIflush : StDone;
         end
         StIflush: state_d = StDone;
         StTlb:    state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   assign wd_active = (state_q == StDrain) || (state_q == StDflush);
   assign wd_enter  = (state_d != state_q) && ((state_d == StDrain) || (state_d == StDflush));
   // One pulse per state visit: fired_q holds off repeats once the counter saturates.
   assign wd_hit    = wd_active && (cnt_q == WdLast) && !fired_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         op_q    <= OpFence;
         cnt_q   <= '0;
         fired_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && state_d == StDrain) op_q <= req_op_i;
         if (wd_enter) begin
            cnt_q   <= '0;
            fired_q <= 1'b0;
         end else if (wd_active) begin
            if (cnt_q != WdLast) cnt_q <= cnt_q + CntWidth'(1);
            else                 fired_q <= 1'b1;
         end
      end
   end

   assign dcache_flush_o   = (state_q == StDflush);
   assign icache_flush_o   = (state_q == StIflush);
   assign tlb_flush_o      = (state_q == StTlb);
   assign flush_pipeline_o = (state_q == StDone);
   assign done_o           = (state_q == StDone) && req_valid_i;
   assign busy_o           = (state_q != StIdle);
   assign timeout_o        = wd_hit;

endmodule

// File: tb/tb_commit_fence_sequencer.sv
// Cycle-accurate vector table for commit_fence_sequencer (TimeoutCycles=8); expected outputs
// are queued when each vector is driven and checked on the opposite clock edge.
module tb_commit_fence_sequencer;

   // Expected-output bit positions: {dflush, iflush, tlb, fpipe, done, busy, timeout}
   localparam logic [6:0] D = 7'b1000000;
   localparam logic [6:0] I = 7'b0100000;
   localparam logic [6:0] T = 7'b0010000;
   localparam logic [6:0] P = 7'b0001000;
   localparam logic [6:0] K = 7'b0000100;
   localparam logic [6:0] B = 7'b0000010;
   localparam logic [6:0] W = 7'b0000001;

   typedef struct {
      int         grp;
      logic       chk;
      logic       rst_n;
      logic       req;
      logic [1:0] op;
      logic       halt;
      logic       nsp;
      logic       ack;
      logic [6:0] exp;
   } vec_t;

   logic       clk = 1'b1;
   logic       rst_n, req_valid, halt, no_st_pending, dflush_ack;
   logic [1:0] req_op;
   logic       dcache_flush, icache_flush, tlb_flush, flush_pipeline, done, busy, timeout;

   vec_t       vecs[$];
   logic [6:0] sb[$];
   int         checks = 0;
   int         errors = 0;
   int         grp = 0;

   always #5 clk = ~clk;

   commit_fence_sequencer #(.TimeoutCycles(8)) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .req_valid_i       (req_valid),
      .req_op_i          (req_op),
      .halt_i            (halt),
      .no_st_pending_i   (no_st_pending),
      .dcache_flush_o    (dcache_flush),
      .dcache_flush_ack_i(dflush_ack),
      .icache_flush_o    (icache_flush),
      .tlb_flush_o       (tlb_flush),
      .flush_pipeline_o  (flush_pipeline),
      .done_o            (done),
      .busy_o            (busy),
      .timeout_o         (timeout)
   );

   task automatic add(input logic r, input logic q, input logic [1:0] o, input logic h,
                      input logic n, input logic a, input logic [6:0] e);
      vec_t v;
      v.grp = grp; v.chk = 1'b1; v.rst_n = r; v.req = q; v.op = o; v.halt = h;
      v.nsp = n; v.ack = a; v.exp = e;
      vecs.push_back(v);
   endtask

   initial begin
      logic [6:0] got, exp;
      vec_t       v;

      // Reset: first vector precedes any clock edge, so it is not checked.
      grp = 0;
      add(0, 0, 2'b00, 0, 0, 0, 7'b0);
      vecs[0].chk = 1'b0;
      add(0, 0, 2'b00, 0, 0, 0, 7'b0);
      add(1, 0, 2'b00, 0, 0, 0, 7'b0);

      // 1: FENCE, stores drained, ack on first DFLUSH cycle
      grp = 1;
      add(1, 1, 2'b00, 0, 1, 0, 7'b0);
      add(1, 1, 2'b00, 0, 1, 0, B);
      add(1, 1, 2'b00, 0, 1, 1, D | B);
      add(1, 1, 2'b00, 0, 1, 0, P | K | B);
      add(1, 0, 2'b00, 0, 1, 0, 7'b0);

      // 2: FENCE_I, DRAIN 5 cycles, DFLUSH 4 cycles; op changes mid-sequence are ignored
      grp = 2;
      add(1, 1, 2'b01, 0, 0, 0, 7'b0);
      for (int k = 0; k < 4; k++) add(1, 1, 2'b10, 0, 0, 0, B);
      add(1, 1, 2'b10, 0, 1, 0, B);
      for (int k = 0; k < 3; k++) add(1, 1, 2'b00, 0, 1, 0, D | B);
      add(1, 1, 2'b00, 0, 1, 1, D | B);
      add(1, 1, 2'b00, 0, 1, 1, I | B);
      add(1, 1, 2'b00, 0, 1, 0, P | K | B);
      add(1, 0, 2'b00, 0, 1, 0, 7'b0);

      // 3: SFENCE_VMA, stray acks ignored
      grp = 3;
      add(1, 1, 2'b10, 0, 1, 1, 7'b0);
      add(1, 1, 2'b10, 0, 1, 1, B);
      add(1, 1, 2'b10, 0, 1, 1, T | B);
      add(1, 1, 2'b10, 0, 1, 0, P | K | B);
      add(1, 0, 2'b10, 0, 1, 0, 7'b0);

      // 4a: abort in DRAIN
      grp = 4;
      add(1, 1, 2'b00, 0, 0, 0, 7'b0);
      add(1, 0, 2'b00, 0, 1, 0, B);
      add(1, 0, 2'b00, 0, 1, 0, 7'b0);
      add(1, 0, 2'b00, 0, 1, 0, 7'b0);
      // 4b: drop in DFLUSH: flush completes, done suppressed
      grp = 5;
      add(1, 1, 2'b00, 0, 1, 0, 7'b0);
      add(1, 1, 2'b00, 0, 1, 0, B);
      add(1, 0, 2'b00, 0, 1, 0, D | B);
      add(1, 0, 2'b00, 0, 1, 1, D | B);
      add(1, 0, 2'b00, 0, 1, 0, P | B);
      add(1, 0, 2'b00, 0, 1, 0, 7'b0);

      // 5: halt blocks start only in IDLE
      grp = 6;
      for (int k = 0; k < 10; k++) add(1, 1, 2'b00, 1, 1, 0, 7'b0);
      add(1, 1, 2'b00, 0, 1, 0, 7'b0);
      add(1, 1, 2'b00, 0, 1, 0, B);
      add(1, 1, 2'b00, 1, 1, 0, D | B);
      add(1, 1, 2'b00, 1, 1, 1, D | B);
      add(1, 1, 2'b00, 1, 1, 0, P | K | B);
      add(1, 1, 2'b00, 1, 1, 0, 7'b0);
      add(1, 0, 2'b00, 0, 1, 0, 7'b0);

      // Back-to-back: req held after DONE starts a new sequence
      grp = 7;
      add(1, 1, 2'b10, 0, 1, 0, 7'b0);
      add(1, 1, 2'b10, 0, 1, 0, B);
      add(1, 1, 2'b10, 0, 1, 0, T | B);
      add(1, 1, 2'b10, 0, 1, 0, P | K | B);
      add(1, 1, 2'b10, 0, 1, 0, 7'b0);
      add(1, 0, 2'b10, 0, 1, 0, B);
      add(1, 0, 2'b10, 0, 1, 0, 7'b0);

      // Reserved op behaves as FENCE
      grp = 8;
      add(1, 1, 2'b11, 0, 1, 0, 7'b0);
      add(1, 1, 2'b11, 0, 1, 0, B);
      add(1, 1, 2'b11, 0, 1, 1, D | B);
      add(1, 1, 2'b11, 0, 1, 0, P | K | B);
      add(1, 0, 2'b11, 0, 1, 0, 7'b0);

      // Watchdog in DFLUSH: one pulse on the 8th DFLUSH cycle
      grp = 9;
      add(1, 1, 2'b00, 0, 1, 0, 7'b0);
      add(1, 1, 2'b00, 0, 1, 0, B);
      for (int k = 1; k <= 9; k++) add(1, 1, 2'b00, 0, 1, 0, (k == 8) ? (D | B | W) : (D | B));
      add(1, 1, 2'b00, 0, 1, 1, D | B);
      add(1, 1, 2'b00, 0, 1, 0, P | K | B);
      add(1, 0, 2'b00, 0, 1, 0, 7'b0);

      // 6: watchdog in DRAIN over 20 cycles, then completion into DFLUSH, then reset there
      grp = 10;
      add(1, 1, 2'b00, 0, 0, 0, 7'b0);
      for (int k = 1; k <= 20; k++) add(1, 1, 2'b00, 0, 0, 0, (k == 8) ? (B | W) : B);
      add(1, 1, 2'b00, 0, 1, 0, B);
      add(1, 1, 2'b00, 0, 1, 0, D | B);
      add(0, 1, 2'b00, 0, 1, 0, D | B);
      add(1, 0, 2'b00, 0, 1, 0, 7'b0);
      add(1, 0, 2'b00, 0, 1, 1, 7'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         v             = vecs[i];
         rst_n         = v.rst_n;
         req_valid     = v.req;
         req_op        = v.op;
         halt          = v.halt;
         no_st_pending = v.nsp;
         dflush_ack    = v.ack;
         if (v.chk) sb.push_back(v.exp);
         @(negedge clk);
         if (v.chk) begin
            got = {dcache_flush, icache_flush, tlb_flush, flush_pipeline, done, busy, timeout};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL vec%0d grp%0d outputs: got %b expected %b", i, v.grp, got, exp);
            end
         end
         @(posedge clk);
         #1;
      end

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
